// File: rtl/intc_pkg.sv
// Shared types and default constants for the interrupt capture / priority arbiter.
package intc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REQ  = 2'b01,
    SVC  = 2'b10
  } state_t;

  localparam logic [31:0] INTC_BASE_ADDR  = 32'h0000_0180;
  localparam logic [31:0] INTC_VEC_STRIDE = 32'h0000_0020;
  localparam int          INTC_PRIO_W     = 4;

  typedef logic [INTC_PRIO_W-1:0] prio_t;

endpackage

// File: rtl/intc_prio_select.sv
// Combinational winner search: highest nonzero priority among candidates, ties to lowest index.
module intc_prio_select
  import intc_pkg::*;
#(
  parameter  int N_SRC  = 4,
  parameter  int PRIO_W = INTC_PRIO_W,
  localparam int IDX_W  = $clog2(N_SRC)
) (
  input  logic [N_SRC-1:0]        cand,
  input  logic [N_SRC*PRIO_W-1:0] prio_flat,
  output logic                    sel_vld,
  output logic [IDX_W-1:0]        sel_idx
);

  logic [N_SRC:0][PRIO_W-1:0] best_prio;
  logic [N_SRC:0][IDX_W-1:0]  best_idx;

  assign best_prio[0] = '0;
  assign best_idx[0]  = '0;

  // Strict greater-than keeps the earlier (lower) index on ties; starting at 0 excludes prio 0.
  for (genvar i = 0; i < N_SRC; i++) begin : g_stage
    logic [PRIO_W-1:0] prio_i;
    logic              take;
    assign prio_i          = prio_flat[i*PRIO_W +: PRIO_W];
    assign take            = cand[i] && (prio_i > best_prio[i]);
    assign best_prio[i+1]  = take ? prio_i : best_prio[i];
    assign best_idx[i+1]   = take ? IDX_W'(i) : best_idx[i];
  end

  assign sel_vld = (best_prio[N_SRC] != '0);
  assign sel_idx = best_idx[N_SRC];

endmodule

// File: rtl/intc_prio_arbiter.sv
// Interrupt capture, priority arbitration and CPU handshake (IDLE -> REQ -> SVC).
// Define INTC_LEVEL_EN for level-sensitive capture; default build uses edge capture.
module intc_prio_arbiter
  import intc_pkg::*;
#(
  parameter  int                N_SRC      = 4,
  parameter  int                PRIO_W     = INTC_PRIO_W,
  parameter  int                ADDR_W     = 32,
  parameter  logic [ADDR_W-1:0] BASE_ADDR  = ADDR_W'(INTC_BASE_ADDR),
  parameter  logic [ADDR_W-1:0] VEC_STRIDE = ADDR_W'(INTC_VEC_STRIDE),
  localparam int                IDX_W      = $clog2(N_SRC)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_SRC-1:0]  irq_in,
  input  logic              cfg_we,
  input  logic [IDX_W-1:0]  cfg_idx,
  input  logic [PRIO_W-1:0] cfg_prio,
  output logic              irq_cpu,
  output logic [ADDR_W-1:0] irq_vec,
  output logic [IDX_W-1:0]  irq_id,
  input  logic              cpu_ack,
  input  logic              cpu_eoi,
  output logic [N_SRC-1:0]  pending,
  output logic              busy
);

  state_t                         state_q, state_d;
  logic [N_SRC-1:0]               pending_q, pending_d;
  logic [N_SRC-1:0][PRIO_W-1:0]   prio_q, prio_d;
  logic                           irq_cpu_q, irq_cpu_d;
  logic [IDX_W-1:0]               irq_id_q, irq_id_d;
  logic [ADDR_W-1:0]              irq_vec_q, irq_vec_d;
  logic                           busy_q, busy_d;

  logic [N_SRC-1:0]               id_onehot;
  logic [N_SRC-1:0]               cand;
  logic                           sel_vld;
  logic [IDX_W-1:0]               sel_idx;

  assign id_onehot = N_SRC'(1) << irq_id_q;

`ifdef INTC_LEVEL_EN
  // Lines are sampled directly; the in-service source cannot win while it is being handled.
  assign pending_d = irq_in;
  assign cand      = pending_q & ~(busy_q ? id_onehot : '0);
`else
  logic [N_SRC-1:0] irq_hist_q;
  logic             ack_clr;

  assign ack_clr   = (state_q == REQ) && cpu_ack;
  // OR-ing the rising edges after the clear lets a same-cycle set win.
  assign pending_d = (pending_q & ~(ack_clr ? id_onehot : '0)) | (irq_in & ~irq_hist_q);
  assign cand      = pending_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) irq_hist_q <= '0;
    else     irq_hist_q <= irq_in;
  end
`endif

  always_comb begin
    prio_d = prio_q;
    if (cfg_we && (int'(cfg_idx) < N_SRC)) prio_d[cfg_idx] = cfg_prio;
  end

  intc_prio_select #(
    .N_SRC  (N_SRC),
    .PRIO_W (PRIO_W)
  ) u_select (
    .cand      (cand),
    .prio_flat (prio_q),
    .sel_vld   (sel_vld),
    .sel_idx   (sel_idx)
  );

  always_comb begin
    state_d   = state_q;
    irq_cpu_d = irq_cpu_q;
    irq_id_d  = irq_id_q;
    irq_vec_d = irq_vec_q;
    busy_d    = busy_q;
    unique case (state_q)
      IDLE: begin
        if (sel_vld) begin
          irq_id_d  = sel_idx;
          irq_vec_d = BASE_ADDR + ADDR_W'(sel_idx) * VEC_STRIDE;
          irq_cpu_d = 1'b1;
          state_d   = REQ;
        end
      end
      REQ: begin
        // cpu_eoi is deliberately ignored here, including when it coincides with cpu_ack.
        if (cpu_ack) begin
          irq_cpu_d = 1'b0;
          busy_d    = 1'b1;
          state_d   = SVC;
        end
      end
      SVC: begin
        if (cpu_eoi) begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        irq_cpu_d = 1'b0;
        busy_d    = 1'b0;
        state_d   = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      pending_q <= '0;
      prio_q    <= '0;
      irq_cpu_q <= 1'b0;
      irq_id_q  <= '0;
      irq_vec_q <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      prio_q    <= prio_d;
      irq_cpu_q <= irq_cpu_d;
      irq_id_q  <= irq_id_d;
      irq_vec_q <= irq_vec_d;
      busy_q    <= busy_d;
    end
  end

  assign irq_cpu = irq_cpu_q;
  assign irq_id  = irq_id_q;
  assign irq_vec = irq_vec_q;
  assign pending = pending_q;
  assign busy    = busy_q;

endmodule

// File: doc/intc_prio_arbiter.md
Name: intc_prio_arbiter

Overview:
- Interrupt capture and priority arbitration stage. Sits between the peripheral interrupt lines and the CPU exception logic.
- Latches requests into pending bits and selects the highest-priority enabled pending source, using 4-bit priority compares.
- Presents one request plus a handler address to the CPU and tracks the in-service source until end-of-interrupt (EOI).

Parameters:
- N_SRC, 4, number of interrupt sources (2..8)
- PRIO_W, 4, priority field width per source
- ADDR_W, 32, handler address width
- BASE_ADDR, 32'h0000_0180, address of the source-0 handler
- VEC_STRIDE, 32'h0000_0020, address spacing between handlers

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- irq_in  in  N_SRC  raw interrupt lines, already synchronous to clk
- cfg_we  in  1  priority register write strobe
- cfg_idx  in  $clog2(N_SRC)  priority register index
- cfg_prio  in  PRIO_W  priority value; 0 = source disabled
- irq_cpu  out  1  interrupt request to CPU
- irq_vec  out  ADDR_W  handler address, valid while irq_cpu=1
- irq_id  out  $clog2(N_SRC)  selected source index
- cpu_ack  in  1  CPU accepted the request (1-cycle pulse)
- cpu_eoi  in  1  end-of-interrupt from handler (1-cycle pulse)
- pending  out  N_SRC  pending bits, for status readback
- busy  out  1  a source is in service

Behaviour:
- Reset (async, rst=1):
  - All priority registers = 0.
  - pending = 0, irq_cpu = 0, irq_vec = 0, irq_id = 0, busy = 0.
  - State = IDLE; edge-detect history = 0.
- Capture:
  - A rising edge on irq_in[i] sets pending[i] on the next clk, irrespective of priority or state.
  - A pending bit is cleared only on cpu_ack for the selected source. If a set and a clear hit the same bit in the same cycle, set wins.
- Selection (combinational over pending and priorities):
  - Candidate: pending[i]=1 and prio[i]!=0.
  - Winner: strictly greatest prio; ties go to the lowest index. Built as a chain of 4-bit greater-than compares.
- FSM IDLE -> REQ -> SVC -> IDLE:
  - IDLE: if any candidate exists, register irq_id = winner and irq_vec = BASE_ADDR + winner*VEC_STRIDE (truncated to ADDR_W), raise irq_cpu, go to REQ. Latency from irq_in edge to irq_cpu is 2 cycles.
  - REQ:
    - irq_cpu stays 1; irq_id and irq_vec are frozen.
    - The winner is not re-evaluated, even if a higher-priority source arrives.
    - On cpu_ack: clear pending[irq_id], drop irq_cpu next cycle, set busy, go to SVC.
    - If the selected source's prio is rewritten to 0 while in REQ, the request is still held until cpu_ack.
  - SVC:
    - New edges are still captured into pending; no new request is issued.
    - On cpu_eoi: clear busy, go to IDLE. Re-arbitration happens on the following cycle, so the next irq_cpu appears 1 cycle after leaving SVC.
  - Ignored inputs:
    - cpu_ack outside REQ is ignored.
    - cpu_eoi outside SVC is ignored.
    - cpu_ack and cpu_eoi asserted together in REQ are treated as ack only.
- Configuration:
  - cfg_we writes prio[cfg_idx] at the clk edge and takes effect on the next arbitration.
  - A cfg_idx >= N_SRC is ignored.
- Reset mid-operation: everything returns to its reset values immediately; there is no pending replay.

Optional Feature:
- Macro: INTC_LEVEL_EN.
- Defined: capture is level-sensitive. pending[i] = irq_in[i] registered each cycle; cpu_ack does not clear it, because the peripheral must deassert its line. While in SVC, the in-service source is masked from arbitration.
- Undefined: edge capture as above.

Decomposition:
- Shared package intc_pkg holds:
  - FSM state enum: IDLE=2'b00, REQ=2'b01, SVC=2'b10.
  - Default BASE_ADDR and VEC_STRIDE constants.
  - Typedef prio_t = logic [PRIO_W-1:0].
- One natural sub-module: intc_prio_select. It is the combinational winner search (pending, priorities -> valid, index), built from per-stage greater-than compares.

Test Plan:
- Single request: prio[2]=5, pulse irq_in[2] -> irq_cpu=1 two cycles later, irq_id=2, irq_vec=32'h0000_01C0. Then cpu_ack -> pending[2]=0 and busy=1; cpu_eoi -> busy=0.
- Priority and tie-break: prio = {3,7,7,0} for idx 0..3, edges on all four in the same cycle -> irq_id=1. After ack+eoi -> irq_id=2; then -> irq_id=0. Source 3 never wins, and pending[3] stays 1.
- Frozen request: prio[0]=2, prio[1]=9; irq_in[0] edge, and while in REQ an irq_in[1] edge -> irq_id stays 0 until ack. After eoi -> irq_id=1.
- Capture during service: in SVC, edge on irq_in[3] with prio[3]=1 -> pending[3]=1, irq_cpu stays 0. cpu_eoi -> irq_cpu=1 one cycle later with irq_id=3.
- Spurious handshake: cpu_ack in IDLE and cpu_eoi in REQ -> no state or pending change.
- Async reset in REQ: rst pulse mid-cycle -> irq_cpu, pending, busy and priorities are 0 immediately. With INTC_LEVEL_EN: holding irq_in[1] high with prio[1]=4 re-requests after eoi until the line drops.
